// File: rtl/prbs_tx.sv
// prbs_tx: PRBS9 (x^9 + x^5 + 1) transmit source, one bit per N_OVERSAMPLE-clock symbol slot.
// Emits o_valid/o_sync strobes and counts completed 511-bit periods.
// Optional single-bit error injection is compiled in when PRBS_ERR_INJECT_EN is defined;
// without it i_err_inject is ignored and o_err_cnt reads 0.
module prbs_tx #(
  parameter logic [8:0]  SEED         = 9'h1FF,
  parameter int unsigned N_OVERSAMPLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  input  logic        i_seed_load,
  input  logic [8:0]  i_seed,
  input  logic        i_err_inject,
  output logic        o_bit,
  output logic        o_valid,
  output logic        o_sync,
  output logic [15:0] o_period_cnt,
  output logic [7:0]  o_err_cnt
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  localparam logic [7:0] TickMax = 8'(N_OVERSAMPLE - 1);
  localparam logic [8:0] IdxLast = 9'd510;

  state_e      state_q, state_d;
  logic [8:0]  lfsr_q, lfsr_d;
  logic [7:0]  tick_q, tick_d;
  logic [8:0]  idx_q, idx_d;
  logic        bit_q, bit_d;
  logic        valid_q, valid_d;
  logic        sync_q, sync_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        emit;
  logic        inj_flip;

  // A bit leaves on the last tick of a slot, unless disabled or overridden by a seed load.
  assign emit = (state_q == StRun) && i_enable && (tick_q == TickMax) && !i_seed_load;

  // Next-state for sequencing, LFSR, emission strobes and the period counter.
  always_comb begin
    state_d = i_enable ? StRun : StIdle;
    lfsr_d  = lfsr_q;
    tick_d  = 8'd0;
    idx_d   = idx_q;
    bit_d   = bit_q;
    valid_d = 1'b0;
    sync_d  = 1'b0;
    pcnt_d  = pcnt_q;

    // Tick only advances while staying in RUN; entering or leaving RUN restarts the slot.
    if ((state_q == StRun) && i_enable && (tick_q != TickMax)) begin
      tick_d = tick_q + 8'd1;
    end

    if (i_seed_load) begin
      lfsr_d = (i_seed == 9'd0) ? SEED : i_seed;
      tick_d = 8'd0;
      idx_d  = 9'd0;
    end else if (emit) begin
      valid_d = 1'b1;
      bit_d   = lfsr_q[8] ^ inj_flip;
      sync_d  = (idx_q == 9'd0);
      lfsr_d  = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
      idx_d   = (idx_q == IdxLast) ? 9'd0 : idx_q + 9'd1;
      if ((idx_q == IdxLast) && (pcnt_q != 16'hFFFF)) begin
        pcnt_d = pcnt_q + 16'd1;
      end
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      tick_q  <= 8'd0;
      idx_q   <= 9'd0;
      bit_q   <= 1'b0;
      valid_q <= 1'b0;
      sync_q  <= 1'b0;
      pcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      tick_q  <= tick_d;
      idx_q   <= idx_d;
      bit_q   <= bit_d;
      valid_q <= valid_d;
      sync_q  <= sync_d;
      pcnt_q  <= pcnt_d;
    end
  end

`ifdef PRBS_ERR_INJECT_EN
  logic       err_arm_q, err_arm_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign inj_flip = err_arm_q;

  // Arm on a pulse (repeat pulses merge), disarm and count on the emission that used it.
  always_comb begin
    err_arm_d = err_arm_q;
    err_cnt_d = err_cnt_q;
    if (emit && err_arm_q) begin
      err_arm_d = 1'b0;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
    if (i_err_inject) begin
      err_arm_d = 1'b1;
    end
  end

  // Injection state, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_arm_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      err_arm_q <= err_arm_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign o_err_cnt = err_cnt_q;
`else
  logic unused_err_inject;

  assign unused_err_inject = i_err_inject;
  assign inj_flip          = 1'b0;
  assign o_err_cnt         = 8'd0;
`endif

  assign o_bit        = bit_q;
  assign o_valid      = valid_q;
  assign o_sync       = sync_q;
  assign o_period_cnt = pcnt_q;

endmodule

// File: tb/tb_prbs_tx.sv
// tb_prbs_tx: randomized self-checking bench for prbs_tx (default SEED=9'h1FF, N_OVERSAMPLE=4).
// Reference: PRBS9 stream from the recurrence b[k+9] = b[k] ^ b[k+4], first 9 bits = seed MSB first.
module tb_prbs_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_enable = 1'b0;
  logic        i_seed_load = 1'b0;
  logic [8:0]  i_seed = 9'd0;
  logic        i_err_inject = 1'b0;
  logic        o_bit;
  logic        o_valid;
  logic        o_sync;
  logic [15:0] o_period_cnt;
  logic [7:0]  o_err_cnt;

  prbs_tx dut (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (i_enable),
    .i_seed_load  (i_seed_load),
    .i_seed       (i_seed),
    .i_err_inject (i_err_inject),
    .o_bit        (o_bit),
    .o_valid      (o_valid),
    .o_sync       (o_sync),
    .o_period_cnt (o_period_cnt),
    .o_err_cnt    (o_err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bit q_bit[$];
  bit q_sync[$];
  int q_cyc[$];
  bit gold[511];

  // Record every emission with the index of the posedge that produced it.
  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
      if (o_valid === 1'b1) begin
        q_bit.push_back(o_bit);
        q_sync.push_back(o_sync);
        q_cyc.push_back(cyc);
      end
    end
  end

  task automatic build_gold(input logic [8:0] s);
    for (int i = 0; i < 9; i++) gold[i] = s[8-i];
    for (int k = 0; k + 9 < 511; k++) gold[k+9] = gold[k] ^ gold[k+4];
  endtask

  task automatic clear_q();
    q_bit.delete();
    q_sync.delete();
    q_cyc.delete();
  endtask

  task automatic wait_records(input int n, input int budget, output bit ok);
    int b;
    b = 0;
    while (q_bit.size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    ok = (q_bit.size() >= n);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b0;
    i_enable = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: observed %0d, expected 0", o_valid); end
    n_cmp++; if (o_sync !== 1'b0) begin n_fail++; $display("FAIL reset_sync: observed %0d, expected 0", o_sync); end
    n_cmp++; if (o_bit !== 1'b0) begin n_fail++; $display("FAIL reset_bit: observed %0d, expected 0", o_bit); end
    n_cmp++; if (o_period_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_pcnt: observed %0d, expected 0", o_period_cnt); end
    n_cmp++; if (o_err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_errcnt: observed %0d, expected 0", o_err_cnt); end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: observed %0d, expected 0", o_valid); end
  endtask

  task automatic test_first_emission();
    int c0, errs;
    bit ok;
    build_gold(9'h1FF);
    clear_q();
    c0 = cyc;
    i_enable = 1'b1;
    wait_records(10, 100, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL first_timeout: observed %0d records, expected 10", q_bit.size());
    end else begin
      n_cmp++; if (q_cyc[0] !== c0 + 5) begin n_fail++; $display("FAIL first_latency: observed cycle %0d, expected %0d", q_cyc[0], c0 + 5); end
      n_cmp++; if (q_sync[0] !== 1'b1) begin n_fail++; $display("FAIL first_sync: observed %0d, expected 1", q_sync[0]); end
      errs = 0;
      for (int i = 0; i < 9; i++) if (q_bit[i] !== 1'b1) errs++;
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL seed_bits: observed %0d non-one bits in 0..8, expected 0", errs); end
      n_cmp++; if (q_bit[9] !== 1'b0) begin n_fail++; $display("FAIL bit9: observed %0d, expected 0", q_bit[9]); end
      errs = 0;
      for (int i = 1; i < 10; i++) begin
        if (q_cyc[i] - q_cyc[i-1] != 4) errs++;
        if (q_sync[i] !== 1'b0) errs++;
      end
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL spacing: observed %0d bad gaps/syncs, expected 0", errs); end
    end
  endtask

  task automatic test_periods();
    int errs, ones, n0;
    bit ok;
    wait_records(1533, 1533 * 4 + 64, ok);
    i_enable = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL periods_timeout: observed %0d records, expected 1533", q_bit.size());
    end else begin
      n_cmp++; if (q_bit.size() != 1533) begin n_fail++; $display("FAIL periods_count: observed %0d records, expected 1533", q_bit.size()); end
      errs = 0;
      for (int i = 0; i < 1533; i++) if (q_sync[i] !== ((i % 511) == 0)) errs++;
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL sync_positions: observed %0d wrong syncs, expected 0", errs); end
      n_cmp++; if (o_period_cnt !== 16'd3) begin n_fail++; $display("FAIL period_cnt: observed %0d, expected 3", o_period_cnt); end
      n0 = 0;
      for (int p = 0; p < 3; p++) begin
        ones = 0;
        for (int i = 0; i < 511; i++) ones += int'(q_bit[p*511 + i]);
        if (ones != 256) n0++;
      end
      n_cmp++; if (n0 != 0) begin n_fail++; $display("FAIL ones_per_period: observed %0d periods without 256 ones, expected 0", n0); end
      errs = 0;
      for (int i = 0; i < 1533; i++) if (q_bit[i] !== gold[i % 511]) errs++;
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL golden_seq: observed %0d wrong bits, expected 0", errs); end
      errs = 0;
      for (int i = 0; i < 1022; i++) if (q_bit[i] !== q_bit[i + 511]) errs++;
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL repeat: observed %0d differing bits, expected 0", errs); end
    end
  endtask

  task automatic test_pause();
    int d, len, sz, c1, errs;
    bit ok;
    clear_q();
    i_enable = 1'b1;
    wait_records(100, 600, ok);
    d = $urandom_range(0, 3);
    repeat (d) @(negedge clk);
    i_enable = 1'b0;
    sz = q_bit.size();
    len = $urandom_range(5, 15);
    repeat (len) @(negedge clk);
    n_cmp++; if (q_bit.size() != sz || sz != 100) begin n_fail++; $display("FAIL pause_quiet: observed %0d records, expected 100", q_bit.size()); end
    c1 = cyc;
    i_enable = 1'b1;
    wait_records(101, 20, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL resume_timeout: observed %0d records, expected 101", q_bit.size());
    end else begin
      n_cmp++; if (q_cyc[100] !== c1 + 5) begin n_fail++; $display("FAIL resume_latency: observed cycle %0d, expected %0d", q_cyc[100], c1 + 5); end
      n_cmp++; if (q_sync[100] !== 1'b0) begin n_fail++; $display("FAIL resume_sync: observed %0d, expected 0", q_sync[100]); end
      errs = 0;
      for (int i = 0; i <= 100; i++) if (q_bit[i] !== gold[i]) errs++;
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL resume_bits: observed %0d wrong bits, expected 0", errs); end
    end
  endtask

  task automatic test_seed_zero();
    int c_load, errs;
    bit ok;
    wait_records(300, 1200, ok);
    repeat (3) @(negedge clk);
    i_seed_load = 1'b1;
    i_seed = 9'd0;
    @(negedge clk);
    i_seed_load = 1'b0;
    c_load = cyc;
    wait_records(320, 120, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL seed0_timeout: observed %0d records, expected 320", q_bit.size());
    end else begin
      n_cmp++; if (q_cyc[300] !== c_load + 4) begin n_fail++; $display("FAIL seed0_suppress: observed cycle %0d, expected %0d", q_cyc[300], c_load + 4); end
      n_cmp++; if (q_sync[300] !== 1'b1) begin n_fail++; $display("FAIL seed0_sync: observed %0d, expected 1", q_sync[300]); end
      n_cmp++; if (q_bit[300] !== 1'b1) begin n_fail++; $display("FAIL seed0_bit: observed %0d, expected 1", q_bit[300]); end
      n_cmp++; if (o_period_cnt !== 16'd3) begin n_fail++; $display("FAIL seed0_pcnt: observed %0d, expected 3", o_period_cnt); end
      errs = 0;
      for (int i = 0; i < 20; i++) if (q_bit[300 + i] !== gold[i]) errs++;
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL seed0_bits: observed %0d wrong bits, expected 0", errs); end
    end
  endtask

  task automatic test_seed_idle();
    logic [8:0] s;
    int c, errs, sync_errs;
    bit ok;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      i_enable = 1'b0;
      repeat ($urandom_range(1, 6)) @(negedge clk);
      s = 9'($urandom_range(1, 511));
      i_seed = s;
      i_seed_load = 1'b1;
      @(negedge clk);
      i_seed_load = 1'b0;
      repeat ($urandom_range(1, 6)) @(negedge clk);
      build_gold(s);
      clear_q();
      c = cyc;
      i_enable = 1'b1;
      wait_records(30, 200, ok);
      n_cmp++;
      if (!ok) begin
        n_fail++; $display("FAIL idle_seed_timeout: observed %0d records, expected 30", q_bit.size());
      end else begin
        n_cmp++; if (q_cyc[0] !== c + 5 || q_sync[0] !== 1'b1) begin n_fail++; $display("FAIL idle_seed_first: observed cycle %0d sync %0d, expected cycle %0d sync 1", q_cyc[0], q_sync[0], c + 5); end
        errs = 0;
        sync_errs = 0;
        for (int i = 0; i < 9; i++) if (q_bit[i] !== s[8-i]) errs++;
        for (int i = 9; i < 30; i++) if (q_bit[i] !== gold[i]) errs++;
        for (int i = 1; i < 30; i++) if (q_sync[i] !== 1'b0) sync_errs++;
        n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL idle_seed_bits: seed %03h observed %0d wrong bits, expected 0", s, errs); end
        n_cmp++; if (sync_errs != 0) begin n_fail++; $display("FAIL idle_seed_sync: observed %0d extra syncs, expected 0", sync_errs); end
      end
    end
  endtask

  task automatic test_err_inject();
    int errs;
    bit ok;
    // Two pulses land inside the slot before emission 30.
    i_err_inject = 1'b1;
    @(negedge clk);
    i_err_inject = 1'b0;
    @(negedge clk);
    i_err_inject = 1'b1;
    @(negedge clk);
    i_err_inject = 1'b0;
    wait_records(50, 200, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL inject_timeout: observed %0d records, expected 50", q_bit.size());
    end else begin
`ifdef PRBS_ERR_INJECT_EN
      n_cmp++; if (q_bit[30] !== ~gold[30]) begin n_fail++; $display("FAIL inject_flip: observed %0d, expected %0d", q_bit[30], ~gold[30]); end
      n_cmp++; if (o_err_cnt !== 8'd1) begin n_fail++; $display("FAIL inject_cnt: observed %0d, expected 1", o_err_cnt); end
`else
      n_cmp++; if (q_bit[30] !== gold[30]) begin n_fail++; $display("FAIL inject_ignored: observed %0d, expected %0d", q_bit[30], gold[30]); end
      n_cmp++; if (o_err_cnt !== 8'd0) begin n_fail++; $display("FAIL inject_cnt: observed %0d, expected 0", o_err_cnt); end
`endif
      errs = 0;
      for (int i = 0; i < 50; i++) if (i != 30 && q_bit[i] !== gold[i]) errs++;
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL inject_others: observed %0d wrong bits, expected 0", errs); end
    end
  endtask

  task automatic test_reset_midrun();
    int c, errs;
    bit ok;
    repeat ($urandom_range(1, 20)) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (o_valid !== 1'b0 || o_sync !== 1'b0 || o_bit !== 1'b0) begin n_fail++; $display("FAIL midrst_out: observed valid %0d sync %0d bit %0d, expected 0 0 0", o_valid, o_sync, o_bit); end
    n_cmp++; if (o_period_cnt !== 16'd0 || o_err_cnt !== 8'd0) begin n_fail++; $display("FAIL midrst_cnt: observed pcnt %0d errcnt %0d, expected 0 0", o_period_cnt, o_err_cnt); end
    rst = 1'b1;
    build_gold(9'h1FF);
    clear_q();
    c = cyc;
    wait_records(12, 100, ok);
    n_cmp++;
    if (!ok) begin
      n_fail++; $display("FAIL midrst_timeout: observed %0d records, expected 12", q_bit.size());
    end else begin
      n_cmp++; if (q_cyc[0] !== c + 5 || q_sync[0] !== 1'b1) begin n_fail++; $display("FAIL midrst_first: observed cycle %0d sync %0d, expected cycle %0d sync 1", q_cyc[0], q_sync[0], c + 5); end
      errs = 0;
      for (int i = 0; i < 12; i++) if (q_bit[i] !== gold[i]) errs++;
      n_cmp++; if (errs != 0) begin n_fail++; $display("FAIL midrst_bits: observed %0d wrong bits, expected 0", errs); end
      n_cmp++; if (o_period_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_pcnt: observed %0d, expected 0", o_period_cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_first_emission();
    test_periods();
    test_pause();
    test_seed_zero();
    test_seed_idle();
    test_err_inject();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
